// File: rtl/vscale_hpm_counter_bank.sv
// Machine-mode HPM counter bank: N event counters with inhibit, sticky overflow and IRQ.
// Optional VSCALE_HPM_USER_READ_EN adds uctren and user read-only counter aliases.
module vscale_hpm_counter_bank #(
    parameter int          NUM_CTRS     = 4,
    parameter int          CTR_WIDTH    = 64,
    parameter int          NUM_EVENTS   = 8,
    parameter logic [11:0] BASE_LO      = 12'hB03,
    parameter logic [11:0] BASE_HI      = 12'hB83,
    parameter logic [11:0] BASE_EVT     = 12'h323,
    parameter logic [11:0] INHIBIT_ADDR = 12'h320,
    parameter logic [11:0] OVF_ADDR     = 12'h7C0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [11:0]           addr,
    input  logic [2:0]            cmd,
    input  logic [31:0]           wdata,
    input  logic [1:0]            prv,
    input  logic [NUM_EVENTS-1:0] events,
    input  logic                  freeze,
    output logic [31:0]           rdata,
    output logic                  hit,
    output logic                  illegal_access,
    output logic                  ovf_irq
);

    localparam int EW  = $clog2(NUM_EVENTS + 1);
    localparam int HW  = CTR_WIDTH - 32;
    localparam int EXT = 1 << EW;
    localparam logic [CTR_WIDTH-1:0] CTR_ONE = 1;
`ifdef VSCALE_HPM_USER_READ_EN
    localparam logic [11:0] UCTREN_ADDR = 12'h306;
    localparam logic [11:0] ULO_BASE    = 12'hC03;
    localparam logic [11:0] UHI_BASE    = 12'hC83;
`endif

    logic [CTR_WIDTH-1:0] ctr_q    [NUM_CTRS];
    logic [CTR_WIDTH-1:0] ctr_d    [NUM_CTRS];
    logic [EW-1:0]        evtsel_q [NUM_CTRS];
    logic [EW-1:0]        evtsel_d [NUM_CTRS];
    logic [NUM_CTRS-1:0]  inhibit_q, inhibit_d;
    logic [NUM_CTRS-1:0]  ovf_q, ovf_d;
    logic [NUM_CTRS-1:0]  ovf_ie_q, ovf_ie_d;
    logic                 ovf_irq_q, ovf_irq_d;
`ifdef VSCALE_HPM_USER_READ_EN
    logic [31:0]          uctren_q, uctren_d;
    logic [NUM_CTRS-1:0]  ulo_sel, uhi_sel;
    logic                 uen_sel;
`endif

    logic                 en, wr, wen;
    logic [NUM_CTRS-1:0]  lo_sel, hi_sel, evt_sel;
    logic                 inh_sel, ovf_sel;
    logic                 alias_deny;
    logic [31:0]          rd_val, new_val;
    logic [EXT-1:0]       evt_ext;
    logic [NUM_CTRS-1:0]  inc, hw_ovf;

    assign en  = cmd[2];
    assign wr  = cmd[1] | cmd[0];
    assign wen = en & wr & ~illegal_access;

    always_comb begin
        lo_sel  = '0;
        hi_sel  = '0;
        evt_sel = '0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            lo_sel[i]  = (addr == BASE_LO + 12'(i));
            hi_sel[i]  = (addr == BASE_HI + 12'(i));
            evt_sel[i] = (addr == BASE_EVT + 12'(i));
        end
        inh_sel = (addr == INHIBIT_ADDR);
        ovf_sel = (addr == OVF_ADDR);
    end

`ifdef VSCALE_HPM_USER_READ_EN
    always_comb begin
        ulo_sel = '0;
        uhi_sel = '0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            ulo_sel[i] = (addr == ULO_BASE + 12'(i));
            uhi_sel[i] = (addr == UHI_BASE + 12'(i));
        end
        uen_sel = (addr == UCTREN_ADDR);
    end

    assign alias_deny = |((ulo_sel | uhi_sel) & ~uctren_q[NUM_CTRS+2:3]);
    assign hit = |{lo_sel, hi_sel, evt_sel, inh_sel, ovf_sel,
                   ulo_sel, uhi_sel, uen_sel};
`else
    assign alias_deny = 1'b0;
    assign hit = |{lo_sel, hi_sel, evt_sel, inh_sel, ovf_sel};
`endif

    // Denied alias reads return zero; other reads are plain register views.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            if (lo_sel[i])  rd_val = ctr_q[i][31:0];
            if (hi_sel[i])  rd_val = 32'(ctr_q[i][CTR_WIDTH-1:32]);
            if (evt_sel[i]) rd_val = 32'(evtsel_q[i]);
`ifdef VSCALE_HPM_USER_READ_EN
            if (ulo_sel[i] && uctren_q[i+3]) rd_val = ctr_q[i][31:0];
            if (uhi_sel[i] && uctren_q[i+3]) rd_val = 32'(ctr_q[i][CTR_WIDTH-1:32]);
`endif
        end
        if (inh_sel) rd_val = 32'(inhibit_q);
        if (ovf_sel) rd_val = 32'(ovf_q) | (32'(ovf_ie_q) << 16);
`ifdef VSCALE_HPM_USER_READ_EN
        if (uen_sel) rd_val = uctren_q;
`endif
    end

    assign rdata = rd_val;

    assign illegal_access = en & (~hit
                                  | (addr[9:8] > prv)
                                  | (wr & (addr[11:10] == 2'b11))
                                  | alias_deny);

    always_comb begin
        new_val = wdata;
        unique case (cmd[1:0])
            2'b10:   new_val = rd_val | wdata;
            2'b11:   new_val = rd_val & ~wdata;
            default: new_val = wdata;
        endcase
    end

    // Index 0 is tied low so evtsel 0 never counts.
    always_comb begin
        evt_ext = '0;
        evt_ext[NUM_EVENTS:1] = events;
    end

    always_comb begin
        for (int i = 0; i < NUM_CTRS; i++) begin
            inc[i] = ~freeze & ~inhibit_q[i] & evt_ext[evtsel_q[i]];
        end
    end

    always_comb begin
        hw_ovf = '0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            ctr_d[i]    = ctr_q[i];
            evtsel_d[i] = evtsel_q[i];
            // A CSR write owns the whole counter for that cycle.
            if (wen && lo_sel[i]) begin
                ctr_d[i] = {ctr_q[i][CTR_WIDTH-1:32], new_val};
            end else if (wen && hi_sel[i]) begin
                ctr_d[i] = {new_val[HW-1:0], ctr_q[i][31:0]};
            end else if (inc[i]) begin
                ctr_d[i]  = ctr_q[i] + CTR_ONE;
                hw_ovf[i] = &ctr_q[i];
            end
            if (wen && evt_sel[i]) begin
                evtsel_d[i] = (new_val > 32'(NUM_EVENTS)) ? '0 : new_val[EW-1:0];
            end
        end

        inhibit_d = inhibit_q;
        if (wen && inh_sel) inhibit_d = new_val[NUM_CTRS-1:0];

        ovf_d    = ovf_q;
        ovf_ie_d = ovf_ie_q;
        if (wen && ovf_sel) begin
            ovf_d    = new_val[NUM_CTRS-1:0];
            ovf_ie_d = new_val[16 +: NUM_CTRS];
        end
        ovf_d     = ovf_d | hw_ovf;
        ovf_irq_d = |(ovf_d & ovf_ie_d);
    end

`ifdef VSCALE_HPM_USER_READ_EN
    always_comb begin
        uctren_d = uctren_q;
        if (wen && uen_sel) uctren_d = new_val;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CTRS; i++) begin
                ctr_q[i]    <= '0;
                evtsel_q[i] <= '0;
            end
            inhibit_q <= '0;
            ovf_q     <= '0;
            ovf_ie_q  <= '0;
            ovf_irq_q <= 1'b0;
`ifdef VSCALE_HPM_USER_READ_EN
            uctren_q  <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_CTRS; i++) begin
                ctr_q[i]    <= ctr_d[i];
                evtsel_q[i] <= evtsel_d[i];
            end
            inhibit_q <= inhibit_d;
            ovf_q     <= ovf_d;
            ovf_ie_q  <= ovf_ie_d;
            ovf_irq_q <= ovf_irq_d;
`ifdef VSCALE_HPM_USER_READ_EN
            uctren_q  <= uctren_d;
`endif
        end
    end

    assign ovf_irq = ovf_irq_q;

endmodule
